// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the 640x480@60 Hz VGA display stage and the
//   bit positions of the RGB332 pixel byte.
//   Default porch and sync values feed the vga_sync_gen parameter defaults.
//   axis_total() derives a line or frame length from its four segments.
package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP; // 800
  localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP; // 525
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;                          // 656
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;                        // 752
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;                          // 490
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;                        // 492

  // RGB332 field layout: RRR GGG BB
  localparam int RED_LSB   = 5;
  localparam int RED_W     = 3;
  localparam int GREEN_LSB = 2;
  localparam int GREEN_W   = 3;
  localparam int BLUE_LSB  = 0;
  localparam int BLUE_W    = 2;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One timing axis (horizontal or vertical): a counter that steps on en and
//   wraps from TOTAL-1 back to 0, plus the active-region and sync-window
//   decodes of the current count.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset, clears the count
//   en       advance the count by one (wrapping)
//   count    current position on the axis
//   active   count < ACTIVE
//   in_sync  SYNC_START <= count < SYNC_END
module vga_axis_counter #(
  parameter int W          = 10,
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         active,
  output logic         in_sync
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT  = W'(ACTIVE);
  localparam logic [W-1:0] SS   = W'(SYNC_START);
  localparam logic [W-1:0] SE   = W'(SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  assign active  = (count < ACT);
  assign in_sync = (count >= SS) && (count < SE);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   640x480@60 Hz VGA timing generator running from a 50 MHz clock with a
//   25 MHz pixel tick. Presents a fetch coordinate to the upstream pattern
//   generator, registers the returned RGB332 pixel one pixel later, and
//   drives colour, sync and blanking at the pins.
// Ports:
//   CLK_50MHz      system clock (only clock)
//   RST_N          asynchronous active-low reset
//   COLOR_DATA_IN  RGB332 pixel for the current CURX/CURY, sampled on the tick
//   CURX, CURY     fetch coordinate; CURY looks ahead to the next line in HBLANK
//   CLK_DATA       25 MHz strobe, rises one cycle after CURX/CURY change
//   HBLANK, VBLANK fetch-aligned blanking
//   HS, VS         pin-aligned sync pulses, active level SYNC_POL
//   BLANK          pin-aligned HBLANK|VBLANK
//   RED/GREEN/BLUE pin colour, zero while BLANK
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       CLK_50MHz,
  input  logic       RST_N,
  input  logic [7:0] COLOR_DATA_IN,
  output logic [9:0] CURX,
  output logic [8:0] CURY,
  output logic       CLK_DATA,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HS,
  output logic       VS,
  output logic       BLANK,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE
);

  localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

  logic       ph;
  logic       tick;
  logic       h_last;
  logic [9:0] hc, vc, vc_next;
  logic       h_active, v_active, h_sync, v_sync;
  logic       blank_now;
  logic [7:0] pix_q;

  // Phase bit: the cycle with ph=1 is the pixel tick. CLK_DATA is the
  // inverted phase delayed one cycle, so it falls on the tick edge and rises
  // one cycle later, centred on a stable fetch coordinate.
  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      ph       <= 1'b0;
      CLK_DATA <= 1'b0;
    end else begin
      ph       <= ~ph;
      CLK_DATA <= ~ph;
    end
  end

  assign tick   = ph;
  assign h_last = (hc == H_LAST);

  vga_axis_counter #(
    .W          (10),
    .TOTAL      (H_TOT),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h (
    .clk     (CLK_50MHz),
    .rst_n   (RST_N),
    .en      (tick),
    .count   (hc),
    .active  (h_active),
    .in_sync (h_sync)
  );

  // Vertical steps on the same tick as the horizontal wrap, so (799,524)
  // goes straight to (0,0).
  vga_axis_counter #(
    .W          (10),
    .TOTAL      (V_TOT),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v (
    .clk     (CLK_50MHz),
    .rst_n   (RST_N),
    .en      (tick & h_last),
    .count   (vc),
    .active  (v_active),
    .in_sync (v_sync)
  );

  assign vc_next = vc + 10'd1;

  // During horizontal blanking the fetch row already points at the next
  // line, wrapping to 0 after the last visible line. In vertical blanking
  // CURY carries only the low 9 bits of VC; nothing is fetched there.
  always_comb begin
    CURX = '0;
    CURY = '0;
    if (h_active) begin
      CURX = hc;
      CURY = vc[8:0];
    end else if (vc_next < V_ACT) begin
      CURY = vc_next[8:0];
    end
  end

  assign HBLANK    = ~h_active;
  assign VBLANK    = ~v_active;
  assign blank_now = ~(h_active & v_active);

  // Pin stage: everything decoded from the current fetch position is
  // latched on the tick, which puts the pins one pixel behind the fetch.
  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      HS    <= ~SYNC_POL;
      VS    <= ~SYNC_POL;
      BLANK <= 1'b1;
      pix_q <= '0;
    end else if (tick) begin
      HS    <= h_sync ? SYNC_POL : ~SYNC_POL;
      VS    <= v_sync ? SYNC_POL : ~SYNC_POL;
      BLANK <= blank_now;
      pix_q <= blank_now ? 8'h00 : COLOR_DATA_IN;
    end
  end

  assign RED   = pix_q[RED_LSB   +: RED_W];
  assign GREEN = pix_q[GREEN_LSB +: GREEN_W];
  assign BLUE  = pix_q[BLUE_LSB  +: BLUE_W];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Directed bench for vga_sync_gen. Horizontal timing is the standard
//   640/16/96/48; the vertical axis is shortened to 12/1/2/1 lines so a
//   whole frame (16 lines = 25600 cycles) fits in a short run.
module tb_vga_sync_gen;

  localparam int C_HS     = 0;
  localparam int C_VS     = 1;
  localparam int C_BLANK  = 2;
  localparam int C_HBLANK = 3;
  localparam int C_VBLANK = 4;
  localparam int C_LINE   = 5;  // CURY==arg while fetching visible pixels
  localparam int C_PIX    = 6;  // CURY==arg and CURX==400

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] color = 8'h00;
  logic [9:0] curx;
  logic [8:0] cury;
  logic       clk_data, hblank, vblank, hs, vs, blank;
  logic [2:0] red, green;
  logic [1:0] blue;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0, t1, t2, t3, th, tv, ts, tv2;

  vga_sync_gen #(
    .V_ACTIVE (12),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1)
  ) dut (
    .CLK_50MHz     (clk),
    .RST_N         (rst_n),
    .COLOR_DATA_IN (color),
    .CURX          (curx),
    .CURY          (cury),
    .CLK_DATA      (clk_data),
    .HBLANK        (hblank),
    .VBLANK        (vblank),
    .HS            (hs),
    .VS            (vs),
    .BLANK         (blank),
    .RED           (red),
    .GREEN         (green),
    .BLUE          (blue)
  );

  // Clock and cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int sel, input int arg);
    case (sel)
      C_HS:     return hs == arg[0];
      C_VS:     return vs == arg[0];
      C_BLANK:  return blank == arg[0];
      C_HBLANK: return hblank == arg[0];
      C_VBLANK: return vblank == arg[0];
      C_LINE:   return (int'(cury) == arg) && !hblank;
      C_PIX:    return (int'(cury) == arg) && (int'(curx) == 400);
      default:  return 1'b0;
    endcase
  endfunction

  // Bounded wait, sampling on the falling edge; returns the cycle count.
  task automatic wait_for(input string tag, input int sel, input int arg,
                          input int lim, output int t);
    int n = 0;
    while (!cond(sel, arg) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_time"}, 32'(cond(sel, arg)), 32'd1);
    t = cyc;
  endtask

  initial begin
    // Reset held for 10 cycles
    rst_n = 1'b0;
    color = 8'hE3;
    repeat (10) @(negedge clk);
    check("rst_curx",     32'(curx),     32'd0);
    check("rst_cury",     32'(cury),     32'd0);
    check("rst_clk_data", 32'(clk_data), 32'd0);
    check("rst_hs",       32'(hs),       32'd1);
    check("rst_vs",       32'(vs),       32'd1);
    check("rst_blank",    32'(blank),    32'd1);
    check("rst_rgb",      32'({red, green, blue}), 32'd0);
    check("rst_hblank",   32'(hblank),   32'd0);
    check("rst_vblank",   32'(vblank),   32'd0);

    // Release: first edge is the non-tick phase, second edge is the tick
    rst_n = 1'b1;
    @(negedge clk);
    check("rel1_curx",     32'(curx),     32'd0);
    check("rel1_clk_data", 32'(clk_data), 32'd1);
    @(negedge clk);
    check("rel2_curx",     32'(curx),     32'd1);
    check("rel2_clk_data", 32'(clk_data), 32'd0);
    // Pixel 0 (0xE3) is now at the pins
    check("e3_red",   32'(red),   32'd7);
    check("e3_green", 32'(green), 32'd0);
    check("e3_blue",  32'(blue),  32'd3);
    check("e3_blank", 32'(blank), 32'd0);

    color = 8'h1C;
    repeat (2) @(negedge clk);
    check("1c_red",   32'(red),   32'd0);
    check("1c_green", 32'(green), 32'd7);
    check("1c_blue",  32'(blue),  32'd0);

    // End of visible line 0: pins still show pixel 639, then go dark
    color = 8'hE3;
    wait_for("hblank_rise0", C_HBLANK, 1, 2000, t0);
    check("px639_red",   32'(red),   32'd7);
    check("px639_blank", 32'(blank), 32'd0);
    check("hblank_curx", 32'(curx),  32'd0);
    check("hblank_cury", 32'(cury),  32'd1);
    repeat (2) @(negedge clk);
    check("px640_blank", 32'(blank), 32'd1);
    check("px640_rgb",   32'({red, green, blue}), 32'd0);

    // Line timing relative to pixel 0 of line 1 reaching the pins
    wait_for("blank_fall1", C_BLANK, 0, 2000, t0);
    wait_for("hs_fall1", C_HS, 0, 2000, t1);
    check("hs_offset", 32'(t1 - t0), 32'd1312);
    wait_for("hs_rise1", C_HS, 1, 2000, t2);
    check("hs_width", 32'(t2 - t1), 32'd192);
    wait_for("hs_fall2", C_HS, 0, 2000, t3);
    check("line_period", 32'(t3 - t1), 32'd1600);

    // Mid-frame reset at (400,5)
    wait_for("pix_5_400", C_PIX, 5, 12000, t0);
    check("pre_rst_red", 32'(red), 32'd7);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_curx",     32'(curx),     32'd0);
    check("mid_rst_cury",     32'(cury),     32'd0);
    check("mid_rst_clk_data", 32'(clk_data), 32'd0);
    check("mid_rst_hs",       32'(hs),       32'd1);
    check("mid_rst_vs",       32'(vs),       32'd1);
    check("mid_rst_blank",    32'(blank),    32'd1);
    check("mid_rst_rgb",      32'({red, green, blue}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart1_curx", 32'(curx), 32'd0);
    check("restart1_cury", 32'(cury), 32'd0);
    @(negedge clk);
    check("restart2_curx", 32'(curx), 32'd1);
    check("restart2_cury", 32'(cury), 32'd0);

    // Lookahead into line 11, then wrap to line 0 from the last visible line
    wait_for("line10", C_LINE, 10, 20000, t0);
    wait_for("hblank_rise10", C_HBLANK, 1, 2000, t0);
    check("look_cury11", 32'(cury), 32'd11);
    wait_for("line11", C_LINE, 11, 2000, t0);
    wait_for("hblank_rise11", C_HBLANK, 1, 2000, th);
    check("look_cury0",   32'(cury),   32'd0);
    check("look_vblank0", 32'(vblank), 32'd0);
    wait_for("vblank_rise", C_VBLANK, 1, 2000, tv);
    check("vblank_delay", 32'(tv - th), 32'd320);
    check("vblank_curx",  32'(curx),    32'd0);

    // Vertical sync: starts one line plus one pixel after VBLANK, 2 lines wide
    wait_for("vs_fall", C_VS, 0, 4000, ts);
    check("vs_offset", 32'(ts - tv), 32'd1602);
    wait_for("vs_rise", C_VS, 1, 4000, t0);
    check("vs_width", 32'(t0 - ts), 32'd3200);

    // Frame period between VBLANK rising edges
    wait_for("vblank_fall", C_VBLANK, 0, 30000, t0);
    wait_for("vblank_rise2", C_VBLANK, 1, 30000, tv2);
    check("frame_period", 32'(tv2 - tv), 32'd25600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
